// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and
// default clock/debounce parameters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } sw_state_e;

  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_DEBOUNCE_MS = 20;

  // Debounce window in clock cycles, never below one cycle.
  function automatic int deb_cycles(input int clk_hz, input int ms);
    int c;
    c = (clk_hz / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: 2-flop synchronizer, stability-window debouncer and
// a one-cycle pulse on each debounced press (high-to-low transition).
module key_debounce #(
  parameter int DEB_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int             CW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // The level follows the synced key only after DEB_CYC consecutive
  // differing samples; any sample equal to the level restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with debounced keys and a one-second tick divider.
// Optional lap/display-freeze feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_reset_n,
  input  logic       key_lap_n,
  output logic       enable,
  output logic       tick,
  output logic       reset_counter,
  output logic       lap_hold,
  output logic [1:0] state_o
);

  localparam int                DEB_CYC = deb_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int                DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_HZ - 1);

  sw_state_e        state;
  sw_state_e        next_state;
  logic             start_press;
  logic             reset_press;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             enable_nxt;
  logic             tick_nxt;
  logic             lap_hold_nxt;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_start (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .press (start_press)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_reset (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_reset_n),
    .press (reset_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_lap (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_lap_n),
    .press (lap_press)
  );
`else
  logic unused_lap;
  assign unused_lap = key_lap_n;
`endif

  // State and all outputs are registered so enable lines up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      enable        <= 1'b0;
      tick          <= 1'b0;
      reset_counter <= 1'b0;
      lap_hold      <= 1'b0;
      div           <= '0;
    end else begin
      state         <= next_state;
      enable        <= enable_nxt;
      tick          <= tick_nxt;
      reset_counter <= reset_press;
      lap_hold      <= lap_hold_nxt;
      div           <= div_nxt;
    end
  end

  // Reset press overrides a simultaneous start press.
  always_comb begin
    next_state = state;
    if (reset_press) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_press) next_state = ST_RUNNING;
        ST_RUNNING: if (start_press) next_state = ST_PAUSED;
        ST_PAUSED:  if (start_press) next_state = ST_RUNNING;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // The divider only advances across cycles that stay in RUNNING, so a
  // pause or reset discards the partial second.
  always_comb begin
    enable_nxt = (next_state == ST_RUNNING);
    div_nxt    = '0;
    tick_nxt   = 1'b0;
    if (state == ST_RUNNING && next_state == ST_RUNNING) begin
      if (div == DIV_MAX) begin
        tick_nxt = 1'b1;
      end else begin
        div_nxt = div + 1'b1;
      end
    end
`ifdef STOPWATCH_LAP_EN
    lap_hold_nxt = lap_hold;
    if (next_state == ST_IDLE) begin
      lap_hold_nxt = 1'b0;
    end else if (lap_press) begin
      if (state == ST_RUNNING) begin
        lap_hold_nxt = ~lap_hold;
      end else if (state == ST_PAUSED) begin
        lap_hold_nxt = 1'b0;
      end
    end
`else
    lap_hold_nxt = 1'b0;
`endif
  end

  assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized self-checking bench for stopwatch_ctrl against a cycle-level
// behavioural model (CLK_HZ=1000, DEBOUNCE_MS=5).
module tb_stopwatch_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 5;
  localparam int DEB         = 5;
  localparam int DEB_MASK    = (1 << DEB) - 1;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_ON = 1'b1;
`else
  localparam logic LAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_reset_n = 1'b1;
  logic       key_lap_n = 1'b1;
  logic       enable;
  logic       tick;
  logic       reset_counter;
  logic       lap_hold;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_start_n   (key_start_n),
    .key_reset_n   (key_reset_n),
    .key_lap_n     (key_lap_n),
    .enable        (enable),
    .tick          (tick),
    .reset_counter (reset_counter),
    .lap_hold      (lap_hold),
    .state_o       (state_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int dut_ticks = 0;
  int model_ticks = 0;

  // Model: index 0 = start, 1 = reset, 2 = lap.
  logic m_d1 [3];
  logic m_d2 [3];
  logic m_level [3];
  logic m_press [3];
  int   m_hist [3];
  int   m_fill [3];
  int   m_state;
  int   m_elapsed;
  logic m_enable, m_tick, m_rc, m_lap;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_d1[k] = 1'b1; m_d2[k] = 1'b1; m_level[k] = 1'b1;
      m_press[k] = 1'b0; m_hist[k] = 0; m_fill[k] = 0;
    end
    m_state = 0; m_elapsed = 0;
    m_enable = 1'b0; m_tick = 1'b0; m_rc = 1'b0; m_lap = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    int   prev, nxt;
    logic seen;
    prev = m_state;
    nxt  = prev;
    if (m_press[1]) nxt = 0;
    else if (m_press[0]) nxt = (prev == 1) ? 2 : 1;
    m_rc     = m_press[1];
    m_enable = (nxt == 1);
    if (prev == 1 && nxt == 1) begin
      m_elapsed++;
      m_tick = ((m_elapsed % CLK_HZ) == 0);
    end else begin
      m_elapsed = 0;
      m_tick    = 1'b0;
    end
    if (m_tick) model_ticks++;
`ifdef STOPWATCH_LAP_EN
    if (nxt == 0) m_lap = 1'b0;
    else if (m_press[2]) begin
      if (prev == 1) m_lap = ~m_lap;
      else if (prev == 2) m_lap = 1'b0;
    end
`endif
    m_state = nxt;
    // A key level flips once the last DEB synced samples all differ from it.
    for (int k = 0; k < 3; k++) begin
      seen    = m_d2[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = raw[k];
      m_hist[k] = ((m_hist[k] << 1) | int'(seen)) & DEB_MASK;
      if (m_fill[k] < DEB) m_fill[k]++;
      m_press[k] = 1'b0;
      if (m_fill[k] == DEB && m_hist[k] == (m_level[k] ? 0 : DEB_MASK)) begin
        m_level[k] = ~m_level[k];
        m_press[k] = ~m_level[k];
        m_hist[k]  = 0;
        m_fill[k]  = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic l, input int n);
    for (int i = 0; i < n; i++) begin
      key_start_n = s;
      key_reset_n = r;
      key_lap_n   = l;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge({l, r, s});
      #1;
      if (tick === 1'b1) dut_ticks++;
      checkOutput("outs", {27'd0, state_o, enable, tick, reset_counter, lap_hold},
                  {27'd0, 2'(m_state), m_enable, m_tick, m_rc, m_lap});
      @(negedge clk);
    end
  endtask

  task automatic pulseReset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("rst_async", {27'd0, state_o, enable, tick, reset_counter, lap_hold}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, n);
    rst = 1'b0;
  endtask

  task automatic pressKey(input int which);
    applyStimulus(which != 0, which != 1, which != 2, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 20);
  endtask

  initial begin
    logic s, r, l;
    int   len;
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    checkOutput("rst_state", {30'd0, state_o}, 32'd0);
    checkOutput("rst_enable", {31'd0, enable}, 32'd0);
    checkOutput("rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("rst_reset_counter", {31'd0, reset_counter}, 32'd0);
    checkOutput("rst_lap_hold", {31'd0, lap_hold}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 5);

    applyStimulus(1'b0, 1'b1, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 20);
    checkOutput("short_press_idle", {30'd0, state_o}, 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 20);
    checkOutput("run_state", {30'd0, state_o}, 32'd1);
    checkOutput("run_enable", {31'd0, enable}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 2500);

    pressKey(0);
    checkOutput("pause_state", {30'd0, state_o}, 32'd2);
    checkOutput("pause_enable", {31'd0, enable}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 500);
    pressKey(0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1200);

    pressKey(1);
    checkOutput("reset_to_idle", {30'd0, state_o}, 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(1'(i % 2), 1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 30);
    checkOutput("bounce_running", {30'd0, state_o}, 32'd1);

    pressKey(2);
    checkOutput("lap_on", {31'd0, lap_hold}, {31'd0, LAP_ON});
    pressKey(2);
    checkOutput("lap_off", {31'd0, lap_hold}, 32'd0);
    pressKey(2);
    pressKey(1);
    checkOutput("lap_cleared_by_reset", {31'd0, lap_hold}, 32'd0);

    pressKey(0);
    pressKey(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 20);
    checkOutput("both_keys_idle", {30'd0, state_o}, 32'd0);

    pressKey(0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1260);
    pulseReset(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1200);
    checkOutput("after_rst_idle", {30'd0, state_o}, 32'd0);

    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulseReset($urandom_range(1, 4));
      end else if ($urandom_range(0, 7) == 0) begin
        applyStimulus(1'b1, 1'b1, 1'b1, $urandom_range(200, 1500));
      end else begin
        s   = ($urandom_range(0, 2) != 0);
        r   = ($urandom_range(0, 5) != 0);
        l   = ($urandom_range(0, 2) != 0);
        len = $urandom_range(1, 12);
        applyStimulus(s, r, l, len);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 20);

    checkOutput("tick_count", dut_ticks, model_ticks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, key stability window in ms.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port key_start_n  input  1  raw start/stop push-button, active-low, asynchronous to clk.
REQ-006 SHALL have port key_reset_n  input  1  raw reset push-button, active-low, asynchronous to clk.
REQ-007 SHALL have port key_lap_n  input  1  raw lap push-button, active-low, asynchronous to clk.
REQ-008 SHALL have port enable  output  1  count enable to the time counter; high only in RUNNING.
REQ-009 SHALL have port tick  output  1  one-cycle pulse once per second while RUNNING.
REQ-010 SHALL have port reset_counter  output  1  one-cycle synchronous clear pulse to the time counter.
REQ-011 SHALL have port lap_hold  output  1  display freeze request.
REQ-012 SHALL have port state_o  output  2  current FSM state encoding.

Function
REQ-013 SHALL pass each key through a 2-flop synchronizer, then a debouncer.
REQ-014 Debouncer: level updates only after synced input holds a new value for DEB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS consecutive cycles; any change restarts the count.
REQ-015 Press event: 1-cycle pulse on each debounced high-to-low transition; release generates nothing.
REQ-016 FSM states: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2; 2'd3 illegal, returns to IDLE next cycle.
REQ-017 IDLE: start press -> RUNNING. RUNNING: start press -> PAUSED. PAUSED: start press -> RUNNING.
REQ-018 Reset press in any state -> IDLE, with reset_counter high for exactly the following cycle.
REQ-019 Start and reset press in the same cycle: reset wins; start discarded.
REQ-020 enable SHALL be registered and equal (state==RUNNING), delayed by zero cycles relative to state_o.
REQ-021 Tick divider counts 0..CLK_HZ-1 only while RUNNING; held at 0 in IDLE and PAUSED.
REQ-022 tick pulses the cycle divider wraps CLK_HZ-1 -> 0; first tick CLK_HZ cycles after entering RUNNING (partial second discarded on pause).
REQ-023 Divider width SHALL be $clog2(CLK_HZ); no overflow beyond CLK_HZ-1.

Reset
REQ-024 On rst: state IDLE, enable 0, tick 0, reset_counter 0, lap_hold 0, divider 0, debounced levels 1 (released), synchronizers 1.
REQ-025 rst asserted mid-second or mid-debounce SHALL discard all partial counts; no press event on rst release while keys remain released.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN defined: lap press in RUNNING toggles lap_hold; lap press in PAUSED clears lap_hold; lap press in IDLE ignored; entering IDLE clears lap_hold.
REQ-027 Macro STOPWATCH_LAP_EN undefined: key_lap_n port present but ignored, no lap debouncer instantiated, lap_hold tied 0.

Structure
REQ-028 Shared package stopwatch_pkg SHALL hold the state encoding constants and the default CLK_HZ/DEBOUNCE_MS values.
REQ-029 Sub-module key_debounce (synchronizer + debouncer + press pulse, parameter DEB_CYC) SHALL be instantiated once per key.
REQ-030 Target 120-400 lines total RTL.

Verification (CLK_HZ=1000, DEBOUNCE_MS=5 -> DEB_CYC=5, tick period 1000 cycles)
REQ-031 Start held low 4 cycles then released -> no state change; held low 20 cycles -> RUNNING, enable=1, first tick exactly 1000 cycles later, then every 1000.
REQ-032 Start bouncing (toggling every 2 cycles for 30 cycles, then steady low) -> exactly one press event, single IDLE->RUNNING transition.
REQ-033 RUNNING 2500 cycles, start press -> PAUSED, enable=0, no tick; start press again -> first tick 1000 cycles after re-entry.
REQ-034 Start and reset debounced in same cycle while PAUSED -> IDLE, reset_counter high one cycle, enable=0.
REQ-035 With STOPWATCH_LAP_EN: lap press in RUNNING -> lap_hold=1; second lap press -> 0; lap_hold=1 then reset press -> lap_hold=0; without macro lap_hold stays 0.
REQ-036 rst pulsed 300 cycles into a second while RUNNING -> all outputs 0, state IDLE, no tick for the remainder.
